ws2812_frame_receiver: RTL and testbench

- Serial-side counterpart of the LED frame transmitter. Decodes the single-wire NRZ pulse-width stream (WS2812 style) back into 24-bit LED frames for 8 LEDs.
- Used as a strip model in system benches and as a loopback checker on hardware.
- Frames are latched to the outputs only when a reset/latch low period is detected, which mirrors the behaviour of a real strip.

---
 rtl/ws2812_pkg.sv | 28 ++
 rtl/ws2812_pulse_classifier.sv | 143 ++++++++++++++
 rtl/ws2812_frame_receiver.sv | 134 +++++++++++++
 tb/tb_ws2812_frame_receiver.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared constants and types for the WS2812 frame receiver.
// Timing values are in clk cycles at CLK_HZ; the FSM encoding is used by the
// pulse classifier.
package ws2812_pkg;

    localparam int unsigned CLK_HZ       = 25_000_000;
    localparam int unsigned MIN_HIGH     = 4;
    localparam int unsigned BIT1_THRESH  = 15;
    localparam int unsigned MAX_HIGH     = 40;
    localparam int unsigned LATCH_CYCLES = 1250;
    localparam int unsigned FRAME_W      = 24;
    localparam int unsigned NUM_LEDS     = 8;

    localparam int unsigned LOW_CNT_W  = $clog2(LATCH_CYCLES + 1);
    localparam int unsigned HIGH_CNT_W = $clog2(MAX_HIGH + 2);
    localparam int unsigned BIT_CNT_W  = $clog2(FRAME_W);
    localparam int unsigned LED_IDX_W  = $clog2(NUM_LEDS + 1);
    localparam int unsigned LED_SEL_W  = $clog2(NUM_LEDS);

    typedef logic [FRAME_W-1:0] frame_t;

    typedef enum logic [1:0] {
        ST_WAIT_LATCH = 2'd0,
        ST_LOW        = 2'd1,
        ST_HIGH       = 2'd2
    } rx_state_e;

endpackage

// File: rtl/ws2812_pulse_classifier.sv
// Synchronizes the WS2812 line, measures high/low widths and classifies them.
// Ports:
//   clk, rstn     clock and asynchronous active-low reset
//   din           raw serial line (asynchronous)
//   bit_strobe    one-cycle pulse per decoded bit, bit_val holds its value
//   glitch        high pulse shorter than MIN_HIGH
//   too_long      high pulse longer than MAX_HIGH (classifier re-syncs)
//   latch_strobe  low period of LATCH_CYCLES after at least one pulse
module ws2812_pulse_classifier
    import ws2812_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic bit_strobe,
    output logic bit_val,
    output logic glitch,
    output logic too_long,
    output logic latch_strobe
);

    localparam int unsigned WIDTH_W = HIGH_CNT_W + 1;

    logic                  sync_meta;
    logic                  din_sync;
    logic                  din_prev;
    logic                  rise_c;
    logic                  fall_c;
    logic [WIDTH_W-1:0]    width_c;

    rx_state_e             state, state_n;
    logic [LOW_CNT_W-1:0]  low_cnt, low_cnt_n;
    logic [HIGH_CNT_W-1:0] high_cnt, high_cnt_n;
    logic                  bit_strobe_n;
    logic                  bit_val_n;
    logic                  glitch_n;
    logic                  too_long_n;
    logic                  latch_n;

    // Two-flop synchronizer plus one register for edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_meta <= 1'b0;
            din_sync  <= 1'b0;
            din_prev  <= 1'b0;
        end else begin
            sync_meta <= din;
            din_sync  <= sync_meta;
            din_prev  <= din_sync;
        end
    end

    assign rise_c  = din_sync & ~din_prev;
    assign fall_c  = ~din_sync & din_prev;
    // The rising-edge cycle itself is part of the pulse, hence the +1
    assign width_c = WIDTH_W'(high_cnt) + WIDTH_W'(1);

    // State, counters and registered event outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_WAIT_LATCH;
            low_cnt      <= '0;
            high_cnt     <= '0;
            bit_strobe   <= 1'b0;
            bit_val      <= 1'b0;
            glitch       <= 1'b0;
            too_long     <= 1'b0;
            latch_strobe <= 1'b0;
        end else begin
            state        <= state_n;
            low_cnt      <= low_cnt_n;
            high_cnt     <= high_cnt_n;
            bit_strobe   <= bit_strobe_n;
            bit_val      <= bit_val_n;
            glitch       <= glitch_n;
            too_long     <= too_long_n;
            latch_strobe <= latch_n;
        end
    end

    // Next-state and event decode
    always_comb begin
        state_n      = state;
        low_cnt_n    = low_cnt;
        high_cnt_n   = high_cnt;
        bit_strobe_n = 1'b0;
        bit_val_n    = bit_val;
        glitch_n     = 1'b0;
        too_long_n   = 1'b0;
        latch_n      = 1'b0;

        case (state)
            ST_WAIT_LATCH: begin
                // Enter LOW already saturated so this sync does not latch
                if (din_sync) begin
                    low_cnt_n = '0;
                end else if (low_cnt == LOW_CNT_W'(LATCH_CYCLES - 1)) begin
                    state_n   = ST_LOW;
                    low_cnt_n = LOW_CNT_W'(LATCH_CYCLES);
                end else begin
                    low_cnt_n = low_cnt + LOW_CNT_W'(1);
                end
            end

            ST_LOW: begin
                // Latch wins over a coincident rising edge; both are honoured
                if (low_cnt == LOW_CNT_W'(LATCH_CYCLES - 1)) begin
                    latch_n = 1'b1;
                end
                if (rise_c) begin
                    state_n    = ST_HIGH;
                    high_cnt_n = '0;
                end else if (low_cnt != LOW_CNT_W'(LATCH_CYCLES)) begin
                    low_cnt_n = low_cnt + LOW_CNT_W'(1);
                end
            end

            ST_HIGH: begin
                if (fall_c) begin
                    state_n   = ST_LOW;
                    low_cnt_n = '0;
                    if (width_c < WIDTH_W'(MIN_HIGH)) begin
                        glitch_n = 1'b1;
                    end else if (width_c > WIDTH_W'(MAX_HIGH)) begin
                        too_long_n = 1'b1;
                        state_n    = ST_WAIT_LATCH;
                    end else begin
                        bit_strobe_n = 1'b1;
                        bit_val_n    = (width_c >= WIDTH_W'(BIT1_THRESH));
                    end
                end else if (high_cnt != HIGH_CNT_W'(MAX_HIGH + 1)) begin
                    high_cnt_n = high_cnt + HIGH_CNT_W'(1);
                end
            end

            default: begin
                state_n   = ST_WAIT_LATCH;
                low_cnt_n = '0;
            end
        endcase
    end

endmodule

// File: rtl/ws2812_frame_receiver.sv
// Decodes a WS2812 NRZ stream into 24-bit frames for NUM_LEDS LEDs and
// presents them when a latch low period is seen.
// Ports:
//   clk, rstn              clock and asynchronous active-low reset
//   din                    serial LED data line (asynchronous)
//   frame_for_led0..7      latched frame per LED, MSB = first bit received
//   frames_valid           one-cycle pulse when a set is latched
//   frames_received        complete frames in the last latched set
//   bit_valid, bit_value   debug strobe and value per decoded bit
//   proto_error            sticky error, cleared by a clean latched set
module ws2812_frame_receiver
    import ws2812_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 din,
    output logic [FRAME_W-1:0]   frame_for_led0,
    output logic [FRAME_W-1:0]   frame_for_led1,
    output logic [FRAME_W-1:0]   frame_for_led2,
    output logic [FRAME_W-1:0]   frame_for_led3,
    output logic [FRAME_W-1:0]   frame_for_led4,
    output logic [FRAME_W-1:0]   frame_for_led5,
    output logic [FRAME_W-1:0]   frame_for_led6,
    output logic [FRAME_W-1:0]   frame_for_led7,
    output logic                 frames_valid,
    output logic [LED_IDX_W-1:0] frames_received,
    output logic                 bit_valid,
    output logic                 bit_value,
    output logic                 proto_error
);

    logic                 bit_strobe;
    logic                 bit_val;
    logic                 glitch;
    logic                 too_long;
    logic                 latch_strobe;

    // Only the 23 earlier bits need storing; the 24th is joined on write
    logic [FRAME_W-2:0]   shreg;
    frame_t               shift_c;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [LED_IDX_W-1:0] led_idx;
    logic [LED_SEL_W-1:0] led_sel_c;
    frame_t               staging [NUM_LEDS];
    frame_t               frame_q [NUM_LEDS];
    logic                 set_dirty;
    logic                 dropping;

    ws2812_pulse_classifier u_classifier (
        .clk          (clk),
        .rstn         (rstn),
        .din          (din),
        .bit_strobe   (bit_strobe),
        .bit_val      (bit_val),
        .glitch       (glitch),
        .too_long     (too_long),
        .latch_strobe (latch_strobe)
    );

    // Debug outputs come straight from the classifier's registers
    assign bit_valid = bit_strobe;
    assign bit_value = bit_val;

    assign shift_c   = {shreg, bit_val};
    assign led_sel_c = led_idx[LED_SEL_W-1:0];

    // Frame assembly, staging and latch
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg           <= '0;
            bit_cnt         <= '0;
            led_idx         <= '0;
            set_dirty       <= 1'b0;
            dropping        <= 1'b0;
            proto_error     <= 1'b0;
            frames_valid    <= 1'b0;
            frames_received <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                staging[i] <= '0;
                frame_q[i] <= '0;
            end
        end else begin
            frames_valid <= 1'b0;
            if (latch_strobe) begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (LED_IDX_W'(i) < led_idx) begin
                        frame_q[i] <= staging[i];
                    end
                end
                frames_received <= led_idx;
                frames_valid    <= 1'b1;
                proto_error     <= set_dirty || (bit_cnt != '0);
                led_idx         <= '0;
                bit_cnt         <= '0;
                set_dirty       <= 1'b0;
                dropping        <= 1'b0;
            end else if (too_long) begin
                // Whole set is abandoned; the classifier re-syncs on a latch
                proto_error <= 1'b1;
                led_idx     <= '0;
                bit_cnt     <= '0;
                set_dirty   <= 1'b0;
                dropping    <= 1'b0;
            end else if (glitch) begin
                proto_error <= 1'b1;
                set_dirty   <= 1'b1;
            end else if (bit_strobe && !dropping) begin
                if (led_idx == LED_IDX_W'(NUM_LEDS)) begin
                    dropping    <= 1'b1;
                    set_dirty   <= 1'b1;
                    proto_error <= 1'b1;
                end else if (bit_cnt == BIT_CNT_W'(FRAME_W - 1)) begin
                    staging[led_sel_c] <= shift_c;
                    led_idx            <= led_idx + LED_IDX_W'(1);
                    bit_cnt            <= '0;
                    shreg              <= '0;
                end else begin
                    shreg   <= shift_c[FRAME_W-2:0];
                    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                end
            end
        end
    end

    assign frame_for_led0 = frame_q[0];
    assign frame_for_led1 = frame_q[1];
    assign frame_for_led2 = frame_q[2];
    assign frame_for_led3 = frame_q[3];
    assign frame_for_led4 = frame_q[4];
    assign frame_for_led5 = frame_q[5];
    assign frame_for_led6 = frame_q[6];
    assign frame_for_led7 = frame_q[7];

endmodule

// File: tb/tb_ws2812_frame_receiver.sv
// Scoreboard bench for ws2812_frame_receiver: stimulus pushes expected bits
// and expected latched sets; a monitor pops and compares on bit_valid and
// frames_valid.
module tb_ws2812_frame_receiver;

    typedef struct packed {
        logic [7:0][23:0] f;
        logic [3:0]       cnt;
        logic             err;
    } set_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        din = 1'b0;
    logic [23:0] frame_for_led0, frame_for_led1, frame_for_led2, frame_for_led3;
    logic [23:0] frame_for_led4, frame_for_led5, frame_for_led6, frame_for_led7;
    logic        frames_valid;
    logic [3:0]  frames_received;
    logic        bit_valid;
    logic        bit_value;
    logic        proto_error;

    logic [7:0][23:0] dut_frames;
    logic [7:0][23:0] model_out;
    logic [7:0][23:0] set_a, set_b, set_c, set_d;
    logic             bitq [$];
    set_t             setq [$];
    int               n_cmp = 0;
    int               n_bad = 0;

    always #5 clk = ~clk;

    ws2812_frame_receiver dut (
        .clk             (clk),
        .rstn            (rstn),
        .din             (din),
        .frame_for_led0  (frame_for_led0),
        .frame_for_led1  (frame_for_led1),
        .frame_for_led2  (frame_for_led2),
        .frame_for_led3  (frame_for_led3),
        .frame_for_led4  (frame_for_led4),
        .frame_for_led5  (frame_for_led5),
        .frame_for_led6  (frame_for_led6),
        .frame_for_led7  (frame_for_led7),
        .frames_valid    (frames_valid),
        .frames_received (frames_received),
        .bit_valid       (bit_valid),
        .bit_value       (bit_value),
        .proto_error     (proto_error)
    );

    assign dut_frames = {frame_for_led7, frame_for_led6, frame_for_led5, frame_for_led4,
                         frame_for_led3, frame_for_led2, frame_for_led1, frame_for_led0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every DUT strobe against the queued expectation
    always begin : monitor
        logic b;
        set_t s;
        @(posedge clk);
        #1;
        if (rstn === 1'b1) begin
            if (bit_valid === 1'b1) begin
                if (bitq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_bit: bit_valid with value %0b, none expected (t=%0t)",
                             bit_value, $time);
                end else begin
                    b = bitq.pop_front();
                    check("bit_value", 32'(bit_value), 32'(b));
                end
            end
            if (frames_valid === 1'b1) begin
                if (setq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_latch: frames_valid with count %0d, none expected (t=%0t)",
                             frames_received, $time);
                end else begin
                    s = setq.pop_front();
                    for (int i = 0; i < 8; i++)
                        check($sformatf("frame_led%0d", i), 32'(dut_frames[i]), 32'(s.f[i]));
                    check("frames_received", 32'(frames_received), 32'(s.cnt));
                    check("latch_proto_error", 32'(proto_error), 32'(s.err));
                    check("bits_pending_at_latch", 32'(bitq.size()), 32'd0);
                end
            end
        end
    end

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    // T0H = 10, T1H = 20, bit period 31
    task automatic send_bit(input logic b, input bit push);
        if (push) bitq.push_back(b);
        if (b) begin hold(1'b1, 20); hold(1'b0, 11); end
        else   begin hold(1'b1, 10); hold(1'b0, 21); end
    endtask

    task automatic send_frame(input logic [23:0] f, input bit push);
        for (int i = 23; i >= 0; i--) send_bit(f[i], push);
    endtask

    task automatic send_frames(input logic [7:0][23:0] fs, input int n, input bit push);
        for (int k = 0; k < n; k++) send_frame(fs[k], push);
    endtask

    task automatic expect_set(input logic [7:0][23:0] fs, input int n, input logic err);
        set_t s;
        for (int k = 0; k < n; k++) model_out[k] = fs[k];
        s.f   = model_out;
        s.cnt = 4'(n);
        s.err = err;
        setq.push_back(s);
    endtask

    initial begin : watchdog
        #700_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin : stimulus
        set_a[0] = 24'h111111; set_a[1] = 24'hBBBBBB; set_a[2] = 24'h333333; set_a[3] = 24'hDDDDDD;
        set_a[4] = 24'h555555; set_a[5] = 24'h777777; set_a[6] = 24'h999999; set_a[7] = 24'h222222;
        set_b[0] = 24'hA5A5A5; set_b[1] = 24'h5A5A5A; set_b[2] = 24'h0F0F0F; set_b[3] = 24'hF0F0F0;
        set_b[4] = 24'h123456; set_b[5] = 24'h789ABC; set_b[6] = 24'hDEF012; set_b[7] = 24'h345678;
        set_c    = '0;
        set_c[0] = 24'hC00001; set_c[1] = 24'hC00002; set_c[2] = 24'hC00003;
        set_d[0] = 24'hFF0000; set_d[1] = 24'h00FF00; set_d[2] = 24'h0000FF; set_d[3] = 24'h800001;
        set_d[4] = 24'h7FFFFE; set_d[5] = 24'hFFFFFF; set_d[6] = 24'h000000; set_d[7] = 24'h6B1E9D;
        model_out = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_frame_led0", 32'(frame_for_led0), 32'd0);
        check("rst_frame_led7", 32'(frame_for_led7), 32'd0);
        check("rst_frames_valid", 32'(frames_valid), 32'd0);
        check("rst_frames_received", 32'(frames_received), 32'd0);
        check("rst_bit_valid", 32'(bit_valid), 32'd0);
        check("rst_bit_value", 32'(bit_value), 32'd0);
        check("rst_proto_error", 32'(proto_error), 32'd0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // Stream joined mid-frame: nothing decoded, first latch is silent
        send_frame(24'hABCDEF, 1'b0);
        hold(1'b0, 1300);

        // Clean set
        send_frames(set_a, 8, 1'b1);
        expect_set(set_a, 8, 1'b0);
        hold(1'b0, 1300);

        // Three frames plus a 10-bit partial
        send_frames(set_c, 3, 1'b1);
        for (int i = 0; i < 10; i++) send_bit(i[0], 1'b1);
        expect_set(set_c, 3, 1'b1);
        hold(1'b0, 1300);
        check("partial_error_sticky", 32'(proto_error), 32'd1);

        // Nine frames: overflow
        send_frames(set_b, 8, 1'b1);
        send_frame(24'hF00F00, 1'b1);
        expect_set(set_b, 8, 1'b1);
        hold(1'b0, 1300);

        // Clean set clears the error
        send_frames(set_d, 8, 1'b1);
        expect_set(set_d, 8, 1'b0);
        hold(1'b0, 1300);
        check("clean_clears_error", 32'(proto_error), 32'd0);

        // Width boundaries: 3 glitch, 4/14 -> 0, 15/40 -> 1, 41 too long
        hold(1'b1, 3);  hold(1'b0, 20);
        check("glitch_sets_error", 32'(proto_error), 32'd1);
        bitq.push_back(1'b0); hold(1'b1, 4);  hold(1'b0, 20);
        bitq.push_back(1'b0); hold(1'b1, 14); hold(1'b0, 20);
        bitq.push_back(1'b1); hold(1'b1, 15); hold(1'b0, 20);
        bitq.push_back(1'b1); hold(1'b1, 40); hold(1'b0, 20);
        hold(1'b1, 41); hold(1'b0, 20);
        check("too_long_error", 32'(proto_error), 32'd1);
        // Back in re-sync: this bit is ignored and the next latch is silent
        send_bit(1'b1, 1'b0);
        hold(1'b0, 1300);

        // Reset after 12 bits of led2
        send_frames(set_a, 2, 1'b1);
        for (int i = 0; i < 12; i++) send_bit(set_a[2][23-i], 1'b1);
        #3;
        rstn = 1'b0;
        #1;
        check("midrst_frame_led0", 32'(frame_for_led0), 32'd0);
        check("midrst_frame_led5", 32'(frame_for_led5), 32'd0);
        check("midrst_frames_received", 32'(frames_received), 32'd0);
        check("midrst_proto_error", 32'(proto_error), 32'd0);
        model_out = '0;
        @(negedge clk);
        rstn = 1'b1;

        // Data before the first full latch period is ignored
        send_frame(set_b[0], 1'b0);
        hold(1'b0, 1300);
        send_frames(set_a, 8, 1'b1);
        expect_set(set_a, 8, 1'b0);
        hold(1'b0, 1300);

        // Latch with no complete frame (set opened by a glitch)
        hold(1'b1, 2);
        expect_set(set_a, 0, 1'b1);
        hold(1'b0, 1300);

        hold(1'b0, 20);
        check("bits_outstanding", 32'(bitq.size()), 32'd0);
        check("sets_outstanding", 32'(setq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
